// File: rtl/y86_fetch_stage.sv
// Y86-64 fetch stage: PC select, byte-addressed instruction memory, field decode,
// valP / next-PC prediction and the F->D pipeline register.
module y86_fetch_stage #(
  parameter int IMEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] F_PC_PREDICT,
  input  logic [3:0]  M_icode,
  input  logic        M_Cnd,
  input  logic [63:0] M_valA,
  input  logic [3:0]  W_icode,
  input  logic [63:0] W_valM,
  input  logic        D_stall,
  input  logic        D_bubble,
  input  logic        load_en,
  input  logic [63:0] load_addr,
  input  logic [7:0]  load_data,
  output logic [63:0] f_PC_PREDICT,
  output logic [63:0] f_pc,
  output logic [2:0]  f_stat,
  output logic [2:0]  D_stat,
  output logic [3:0]  D_icode,
  output logic [3:0]  D_ifun,
  output logic [3:0]  D_rA,
  output logic [3:0]  D_rB,
  output logic [63:0] D_valC,
  output logic [63:0] D_valP
);

  localparam int          AW      = (IMEM_BYTES > 1) ? $clog2(IMEM_BYTES) : 1;
  localparam int          WIN     = 10;
  localparam logic [63:0] LAST_PC = 64'(IMEM_BYTES - WIN);

  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  localparam logic [3:0] I_HALT = 4'h0;
  localparam logic [3:0] I_NOP  = 4'h1;
  localparam logic [3:0] I_JXX  = 4'h7;
  localparam logic [3:0] I_CALL = 4'h8;
  localparam logic [3:0] I_RET  = 4'h9;
  localparam logic [3:0] R_NONE = 4'hF;

  typedef struct packed {
    logic [2:0]  stat;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
  } dreg_t;

  localparam dreg_t BUBBLE = '{stat: S_AOK, icode: I_NOP, ifun: 4'h0, ra: R_NONE,
                               rb: R_NONE, valc: 64'h0, valp: 64'h0};

  // Instruction memory: no reset, written one byte per cycle through the load port
  logic [7:0] mem_q [IMEM_BYTES];

  always_ff @(posedge clk) begin
    if (load_en && (load_addr < 64'(IMEM_BYTES)))
      mem_q[AW'(load_addr)] <= load_data;
  end

  // PC select: mispredicted branch in M beats return address in W
  logic imem_error;

  always_comb begin
    f_pc = F_PC_PREDICT;
    if (M_icode == I_JXX && !M_Cnd) f_pc = M_valA;
    else if (W_icode == I_RET)      f_pc = W_valM;
    imem_error = (f_pc > LAST_PC);
  end

  // 10-byte fetch window; forced to zero when any byte would fall outside memory
  logic [WIN-1:0][7:0] win;

  always_comb begin
    for (int i = 0; i < WIN; i++) begin
      win[i] = 8'h00;
      if (!imem_error) win[i] = mem_q[AW'(f_pc + 64'(i))];
    end
  end

  logic [3:0]  icode, ifun, ra, rb;
  logic        need_regids, need_valc, instr_valid;
  logic [63:0] valc, valp;

  always_comb begin
    icode = imem_error ? I_NOP : win[0][7:4];
    ifun  = imem_error ? 4'h0  : win[0][3:0];

    need_regids = icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB};
    need_valc   = icode inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8};

    ra   = need_regids ? win[1][7:4] : R_NONE;
    rb   = need_regids ? win[1][3:0] : R_NONE;
    valc = 64'h0;
    if (need_valc) valc = need_regids ? win[9:2] : win[8:1];

    valp = f_pc + 64'd1 + 64'(need_regids) + (need_valc ? 64'd8 : 64'd0);

    unique case (icode)
      4'h0, 4'h1, 4'h3, 4'h4, 4'h5,
      4'h8, 4'h9, 4'hA, 4'hB:        instr_valid = (ifun == 4'h0);
      4'h2, 4'h7:                    instr_valid = (ifun <= 4'h6);
      4'h6:                          instr_valid = (ifun <= 4'h3);
      default:                       instr_valid = 1'b0;
    endcase

    if (imem_error)        f_stat = S_ADR;
    else if (!instr_valid) f_stat = S_INS;
    else if (icode == I_HALT) f_stat = S_HLT;
    else                   f_stat = S_AOK;

    f_PC_PREDICT = (icode == I_JXX || icode == I_CALL) ? valc : valp;
  end

  // F->D register: stall dominates bubble, reset dominates both
  dreg_t d_q, d_d, fetch;

  always_comb begin
    fetch = '{stat: f_stat, icode: icode, ifun: ifun, ra: ra, rb: rb,
              valc: valc, valp: valp};
    d_d = fetch;
    if (D_stall)       d_d = d_q;
    else if (D_bubble) d_d = BUBBLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) d_q <= BUBBLE;
    else        d_q <= d_d;
  end

  assign D_stat  = d_q.stat;
  assign D_icode = d_q.icode;
  assign D_ifun  = d_q.ifun;
  assign D_rA    = d_q.ra;
  assign D_rB    = d_q.rb;
  assign D_valC  = d_q.valc;
  assign D_valP  = d_q.valp;

endmodule

// File: tb/tb_y86_fetch_stage.sv
// Bench for y86_fetch_stage: vector table, hand sequences for D control and the
// load port, then randomized traffic against a spec-level reference model.
module tb_y86_fetch_stage;
  localparam int IMEM = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] F_PC_PREDICT, M_valA, W_valM, load_addr;
  logic [3:0]  M_icode, W_icode;
  logic        M_Cnd, D_stall, D_bubble, load_en;
  logic [7:0]  load_data;
  logic [63:0] f_PC_PREDICT, f_pc, D_valC, D_valP;
  logic [2:0]  f_stat, D_stat;
  logic [3:0]  D_icode, D_ifun, D_rA, D_rB;

  y86_fetch_stage #(.IMEM_BYTES(IMEM)) dut (
    .clk(clk), .rst_n(rst_n), .F_PC_PREDICT(F_PC_PREDICT), .M_icode(M_icode),
    .M_Cnd(M_Cnd), .M_valA(M_valA), .W_icode(W_icode), .W_valM(W_valM),
    .D_stall(D_stall), .D_bubble(D_bubble), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .f_PC_PREDICT(f_PC_PREDICT),
    .f_pc(f_pc), .f_stat(f_stat), .D_stat(D_stat), .D_icode(D_icode),
    .D_ifun(D_ifun), .D_rA(D_rA), .D_rB(D_rB), .D_valC(D_valC), .D_valP(D_valP)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem_m [IMEM];

  typedef struct {
    logic [2:0]  stat;
    logic [3:0]  icode, ifun, ra, rb;
    logic [63:0] valc, valp, pred;
  } ref_t;

  typedef struct {
    logic [63:0] pc;
    logic [3:0]  mi;
    logic        mc;
    logic [63:0] ma;
    logic [3:0]  wi;
    logic [63:0] wv;
    logic [63:0] fpc;
    logic [2:0]  stat;
    logic [3:0]  icode, ra, rb;
    logic [63:0] valc, valp, pred;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic ref_t bubble_val();
    ref_t r;
    r.stat = 3'd1; r.icode = 4'h1; r.ifun = 4'h0; r.ra = 4'hF; r.rb = 4'hF;
    r.valc = 64'h0; r.valp = 64'h0; r.pred = 64'h0;
    return r;
  endfunction

  // Reference fetch straight from the ISA rules, using the bench's memory image
  function automatic ref_t ref_fetch(input logic [63:0] pc);
    ref_t r;
    int p, nr, nc;
    logic inval;
    if (pc > 64'(IMEM - 10)) begin
      r.stat = 3'd3; r.icode = 4'h1; r.ifun = 4'h0; r.ra = 4'hF; r.rb = 4'hF;
      r.valc = 64'h0; r.valp = pc + 64'd1; r.pred = r.valp;
      return r;
    end
    p = int'(pc);
    r.icode = mem_m[p][7:4];
    r.ifun  = mem_m[p][3:0];
    nr = (r.icode inside {4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB}) ? 1 : 0;
    nc = (r.icode inside {4'h3, 4'h4, 4'h5, 4'h7, 4'h8}) ? 1 : 0;
    r.ra = (nr == 1) ? mem_m[p+1][7:4] : 4'hF;
    r.rb = (nr == 1) ? mem_m[p+1][3:0] : 4'hF;
    r.valc = 64'h0;
    if (nc == 1)
      for (int k = 0; k < 8; k++) r.valc = r.valc | (64'(mem_m[p+1+nr+k]) << (8*k));
    r.valp = pc + 64'(1 + nr + 8*nc);
    inval = (r.icode > 4'hB) ||
            (r.ifun != 0 && (r.icode inside {4'h0, 4'h1, 4'h3, 4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB})) ||
            (r.icode == 4'h6 && r.ifun > 4'h3) ||
            ((r.icode == 4'h7 || r.icode == 4'h2) && r.ifun > 4'h6);
    r.stat = inval ? 3'd4 : (r.icode == 4'h0) ? 3'd2 : 3'd1;
    r.pred = (r.icode == 4'h7 || r.icode == 4'h8) ? r.valc : r.valp;
    return r;
  endfunction

  task automatic idle();
    M_icode = 4'h0; M_Cnd = 1'b0; M_valA = 64'h0; W_icode = 4'h0; W_valM = 64'h0;
    D_stall = 1'b0; D_bubble = 1'b0; load_en = 1'b0; load_addr = 64'h0; load_data = 8'h0;
  endtask

  task automatic poke(input int a, input logic [7:0] d);
    @(negedge clk);
    load_en = 1'b1; load_addr = 64'(a); load_data = d;
    @(posedge clk);
    mem_m[a] = d;
    #1 load_en = 1'b0;
  endtask

  task automatic poke_seq(input int a, input logic [79:0] bytes, input int n);
    for (int i = 0; i < n; i++) poke(a + i, bytes[79-8*i -: 8]);
  endtask

  vec_t  tv[$];
  ref_t  e, d_m;
  logic [63:0] pc_sel;
  logic        wr_hit;
  int          wr_a;
  logic [7:0]  wr_d;

  initial begin
    for (int i = 0; i < IMEM; i++) mem_m[i] = 8'h00;
    idle();
    F_PC_PREDICT = 64'h0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("reset_icode", 64'(D_icode), 64'h1);
    chk("reset_rArB",  64'({D_rA, D_rB}), 64'hFF);
    chk("reset_valP",  D_valP, 64'h0);
    chk("reset_stat",  64'(D_stat), 64'd1);

    // Program image; explicit zero bytes keep the image independent of power-up state
    poke_seq(32'h00,  80'h30F20A00000000000000, 10);
    poke_seq(32'h20,  80'h70400000000000000000, 9);
    poke(32'h29, 8'h10);
    poke_seq(32'h40,  80'h80000100000000000000, 9);
    poke(32'h60, 8'hC0);
    poke_seq(32'h62,  80'h61236423000000000000, 5);
    poke(32'h100, 8'h90);
    poke(1014, 8'h00);
    rst_n = 1'b1;

    //          pc        mi  mc ma       wi  wv        fpc       st icode ra   rb   valc      valp     pred
    tv.push_back('{64'h0,    0, 0, 64'h0,  0, 64'h0,   64'h0,    1, 4'h3, 4'hF, 4'h2, 64'd10,  64'd10,  64'd10});
    tv.push_back('{64'h20,   0, 0, 64'h0,  0, 64'h0,   64'h20,   1, 4'h7, 4'hF, 4'hF, 64'h40,  64'h29,  64'h40});
    tv.push_back('{64'h40,   0, 0, 64'h0,  0, 64'h0,   64'h40,   1, 4'h8, 4'hF, 4'hF, 64'h100, 64'h49,  64'h100});
    tv.push_back('{64'h60,   0, 0, 64'h0,  0, 64'h0,   64'h60,   4, 4'hC, 4'hF, 4'hF, 64'h0,   64'h61,  64'h61});
    tv.push_back('{64'h62,   0, 0, 64'h0,  0, 64'h0,   64'h62,   1, 4'h6, 4'h2, 4'h3, 64'h0,   64'h64,  64'h64});
    tv.push_back('{64'h64,   0, 0, 64'h0,  0, 64'h0,   64'h64,   4, 4'h6, 4'h2, 4'h3, 64'h0,   64'h66,  64'h66});
    tv.push_back('{64'h66,   0, 0, 64'h0,  0, 64'h0,   64'h66,   2, 4'h0, 4'hF, 4'hF, 64'h0,   64'h67,  64'h67});
    tv.push_back('{64'h100,  0, 0, 64'h0,  0, 64'h0,   64'h100,  1, 4'h9, 4'hF, 4'hF, 64'h0,   64'h101, 64'h101});
    tv.push_back('{64'd1015, 0, 0, 64'h0,  0, 64'h0,   64'd1015, 3, 4'h1, 4'hF, 4'hF, 64'h0,   64'd1016, 64'd1016});
    tv.push_back('{64'd1014, 0, 0, 64'h0,  0, 64'h0,   64'd1014, 2, 4'h0, 4'hF, 4'hF, 64'h0,   64'd1015, 64'd1015});
    tv.push_back('{'1,       0, 0, 64'h0,  0, 64'h0,   '1,       3, 4'h1, 4'hF, 4'hF, 64'h0,   64'h0,   64'h0});
    tv.push_back('{64'h500,  7, 0, 64'h29, 0, 64'h0,   64'h29,   1, 4'h1, 4'hF, 4'hF, 64'h0,   64'h2A,  64'h2A});
    tv.push_back('{64'h500,  0, 0, 64'h0,  9, 64'h100, 64'h100,  1, 4'h9, 4'hF, 4'hF, 64'h0,   64'h101, 64'h101});
    tv.push_back('{64'h500,  7, 0, 64'h29, 9, 64'h100, 64'h29,   1, 4'h1, 4'hF, 4'hF, 64'h0,   64'h2A,  64'h2A});
    tv.push_back('{64'h20,   7, 1, 64'h29, 0, 64'h0,   64'h20,   1, 4'h7, 4'hF, 4'hF, 64'h40,  64'h29,  64'h40});
    tv.push_back('{64'h62,   6, 0, 64'h29, 0, 64'h0,   64'h62,   1, 4'h6, 4'h2, 4'h3, 64'h0,   64'h64,  64'h64});

    foreach (tv[i]) begin
      @(negedge clk);
      F_PC_PREDICT = tv[i].pc; M_icode = tv[i].mi; M_Cnd = tv[i].mc; M_valA = tv[i].ma;
      W_icode = tv[i].wi; W_valM = tv[i].wv;
      #1;
      chk($sformatf("v%0d_f_pc", i),   f_pc, tv[i].fpc);
      chk($sformatf("v%0d_f_stat", i), 64'(f_stat), 64'(tv[i].stat));
      chk($sformatf("v%0d_pred", i),   f_PC_PREDICT, tv[i].pred);
      @(posedge clk); #1;
      chk($sformatf("v%0d_D_icode", i), 64'(D_icode), 64'(tv[i].icode));
      chk($sformatf("v%0d_D_rArB", i),  64'({D_rA, D_rB}), 64'({tv[i].ra, tv[i].rb}));
      chk($sformatf("v%0d_D_valC", i),  D_valC, tv[i].valc);
      chk($sformatf("v%0d_D_valP", i),  D_valP, tv[i].valp);
      chk($sformatf("v%0d_D_stat", i),  64'(D_stat), 64'(tv[i].stat));
    end
    idle();

    // Stall holds D while fetch keeps predicting from the live PC
    @(negedge clk); F_PC_PREDICT = 64'h0;
    @(posedge clk); #1 chk("pre_stall_icode", 64'(D_icode), 64'h3);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); F_PC_PREDICT = 64'h20; D_stall = 1'b1;
      #1 chk("stall_pred", f_PC_PREDICT, 64'h40);
      @(posedge clk); #1;
      chk("stall_icode", 64'(D_icode), 64'h3);
      chk("stall_valP",  D_valP, 64'd10);
    end
    @(negedge clk); D_stall = 1'b0; D_bubble = 1'b1;
    @(posedge clk); #1;
    chk("bubble_icode", 64'(D_icode), 64'h1);
    chk("bubble_rArB",  64'({D_rA, D_rB}), 64'hFF);
    chk("bubble_valP",  D_valP, 64'h0);
    @(negedge clk); D_bubble = 1'b0;
    @(posedge clk); #1 chk("reload_icode", 64'(D_icode), 64'h7);
    @(negedge clk); F_PC_PREDICT = 64'h0; D_stall = 1'b1; D_bubble = 1'b1;
    @(posedge clk); #1;
    chk("stall_bubble_icode", 64'(D_icode), 64'h7);
    chk("stall_bubble_valC",  D_valC, 64'h40);
    @(negedge clk); D_bubble = 1'b0; rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_in_stall_icode", 64'(D_icode), 64'h1);
    chk("rst_in_stall_valP",  D_valP, 64'h0);
    @(negedge clk); rst_n = 1'b1; D_stall = 1'b0; F_PC_PREDICT = 64'h40;
    @(posedge clk); #1 chk("post_rst_valP", D_valP, 64'h49);

    // Load port: write becomes visible one cycle later; out-of-range write is dropped
    @(negedge clk); F_PC_PREDICT = 64'd5; load_en = 1'b1; load_addr = 64'd5; load_data = 8'h10;
    #1 chk("pre_write_stat", 64'(f_stat), 64'd2);
    @(posedge clk); mem_m[5] = 8'h10;
    @(negedge clk); load_en = 1'b0;
    #1 chk("post_write_pred", f_PC_PREDICT, 64'd6);
    @(posedge clk); #1;
    chk("post_write_icode", 64'(D_icode), 64'h1);
    chk("post_write_valP",  D_valP, 64'd6);
    @(negedge clk); load_en = 1'b1; load_addr = 64'(IMEM); load_data = 8'hFF;
    @(negedge clk); load_addr = 64'h1_0000_0000; F_PC_PREDICT = 64'h0;
    @(negedge clk); load_en = 1'b0;
    #1;
    chk("oob_write_stat", 64'(f_stat), 64'd1);
    chk("oob_write_pred", f_PC_PREDICT, 64'd10);

    // Random region image, biased toward legal opcodes
    for (int a = 32'h200; a < 32'h290; a++)
      poke(a, ($urandom_range(1) == 1) ? {4'($urandom_range(11)), 4'($urandom_range(3))}
                                       : 8'($urandom));
    for (int a = 1000; a < 1014; a++) poke(a, 8'($urandom));

    d_m = bubble_val();
    @(negedge clk); D_bubble = 1'b1;
    @(posedge clk);
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      case ($urandom_range(9))
        0:       F_PC_PREDICT = 64'(1005 + $urandom_range(20));
        1:       F_PC_PREDICT = {$urandom, $urandom};
        default: F_PC_PREDICT = 64'(32'h200 + $urandom_range(32'h7F));
      endcase
      M_icode = ($urandom_range(3) == 0) ? 4'h7 : 4'($urandom);
      M_Cnd   = 1'($urandom);
      M_valA  = 64'(32'h200 + $urandom_range(32'h7F));
      W_icode = ($urandom_range(3) == 0) ? 4'h9 : 4'($urandom);
      W_valM  = 64'(32'h200 + $urandom_range(32'h7F));
      D_stall  = ($urandom_range(5) == 0);
      D_bubble = ($urandom_range(5) == 0);
      rst_n    = ($urandom_range(19) != 0);
      load_en  = ($urandom_range(2) == 0);
      load_addr = ($urandom_range(9) == 0) ? 64'(IMEM + $urandom_range(7))
                                           : 64'(32'h200 + $urandom_range(32'h8F));
      load_data = 8'($urandom);
      #1;
      if (M_icode == 4'h7 && !M_Cnd) pc_sel = M_valA;
      else if (W_icode == 4'h9)      pc_sel = W_valM;
      else                           pc_sel = F_PC_PREDICT;
      e = ref_fetch(pc_sel);
      chk("rnd_f_pc",   f_pc, pc_sel);
      chk("rnd_f_stat", 64'(f_stat), 64'(e.stat));
      chk("rnd_pred",   f_PC_PREDICT, e.pred);
      wr_hit = load_en && (load_addr < 64'(IMEM));
      wr_a = int'(load_addr[31:0]);
      wr_d = load_data;
      @(posedge clk);
      if (!rst_n)        d_m = bubble_val();
      else if (D_stall)  d_m = d_m;
      else if (D_bubble) d_m = bubble_val();
      else               d_m = e;
      if (wr_hit) mem_m[wr_a] = wr_d;
      #1;
      chk("rnd_D", {D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC[39:0]},
                   {d_m.stat, d_m.icode, d_m.ifun, d_m.ra, d_m.rb, d_m.valc[39:0]});
      chk("rnd_D_valP", D_valP, d_m.valp);
      chk("rnd_D_valC", D_valC, d_m.valc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
